// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory handshake and the decode-stage handoff.
// The sequencer drives it through the master modport; memory and decode use the slave modport.
interface fetch_sequencer_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ack;
    logic            branch_taken;
    logic [XLEN-1:0] branch_off;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rdata, inst_ack, branch_taken, branch_off
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rdata, inst_ack, branch_taken, branch_off
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: requests one instruction at a time, holds it for decode,
// then steps the PC sequentially or to a branch target and traps misaligned targets.
module fetch_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt,
    fetch_sequencer_if.master   bus,
    output logic                pc_sel,
    output logic [31:0]         inst_count,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic        [XLEN-1:0]   pc_q, pc_d;
    logic        [31:0]       inst_q, inst_d;
    logic        [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic                     inst_valid_q, inst_valid_d;
    logic                     pc_sel_q, pc_sel_d;
    logic        [31:0]       cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic signed [XLEN-1:0]   off_s;
    logic        [XLEN-1:0]   target;

    // Modulo-2^XLEN add: a carry out of the top bit is simply dropped.
    assign off_s  = bus.branch_off;
    assign target = bus.branch_taken ? XLEN'($signed(inst_pc_q) + off_s)
                                     : inst_pc_q + XLEN'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_sel_d     = pc_sel_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ready) begin
                    inst_d       = bus.imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.inst_ack) begin
                    pc_d         = target;
                    pc_sel_d     = bus.branch_taken;
                    cnt_d        = cnt_q + 32'd1;
                    inst_valid_d = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (halt) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR: begin
                inst_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            pc_sel_q     <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            pc_sel_q     <= pc_sel_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign pc_sel         = pc_sel_q;
    assign inst_count     = cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a scoreboard queue records each word handed to the
// sequencer and is checked against the instruction it presents to decode.
module tb_fetch_sequencer;

    localparam int XLEN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic        pc_sel;
    logic [31:0] inst_count;
    logic        err;

    fetch_sequencer_if #(.XLEN(XLEN)) bus ();

    fetch_sequencer #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .bus        (bus.master),
        .pc_sel     (pc_sel),
        .inst_count (inst_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start            = 1'b0;
        halt             = 1'b0;
        bus.imem_ready   = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.inst_ack     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_off   = 64'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Serve one request at the expected address after 'stall' not-ready cycles.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] word, input int stall);
        int  w;
        sb_t e;
        w = 0;
        while (bus.imem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_seen", 64'(bus.imem_req), 64'd1);
        chk("imem_addr", bus.imem_addr, addr);
        for (int i = 0; i < stall; i++) begin
            bus.imem_ready = 1'b0;
            @(negedge clk);
            chk("stall_req", 64'(bus.imem_req), 64'd1);
            chk("stall_addr", bus.imem_addr, addr);
            chk("stall_valid", 64'(bus.inst_valid), 64'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        sb.push_back('{pc: addr, word: word});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        chk("hold_valid", 64'(bus.inst_valid), 64'd1);
        chk("hold_req", 64'(bus.imem_req), 64'd0);
        chk("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("inst", 64'(bus.inst), 64'(e.word));
            chk("inst_pc", bus.inst_pc, e.pc);
        end
    endtask

    task automatic accept(input logic bt, input logic [63:0] off, input logic h);
        bus.inst_ack     = 1'b1;
        bus.branch_taken = bt;
        bus.branch_off   = off;
        halt             = h;
        @(negedge clk);
        bus.inst_ack     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_off   = 64'h0;
        halt             = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", bus.imem_addr, 64'h0);
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        chk("rst_pc_sel", 64'(pc_sel), 64'd0);
        chk("rst_count", 64'(inst_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // IDLE ignores halt and ack
        halt = 1'b1;
        bus.inst_ack = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("idle_req", 64'(bus.imem_req), 64'd0);
        chk("idle_count", 64'(inst_count), 64'd0);

        // T1: two sequential fetches, zero-wait memory
        kick();
        fetch(64'h0, 32'h0050_0093, 0);
        // branch/halt without ack must not disturb HOLD
        bus.branch_taken = 1'b1;
        bus.branch_off   = 64'h100;
        halt             = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("hold_stable_valid", 64'(bus.inst_valid), 64'd1);
        chk("hold_stable_inst", 64'(bus.inst), 64'h0050_0093);
        chk("hold_stable_req", 64'(bus.imem_req), 64'd0);
        accept(1'b0, 64'h0, 1'b0);
        chk("t1_req_next", 64'(bus.imem_req), 64'd1);
        chk("t1_pc_sel", 64'(pc_sel), 64'd0);
        fetch(64'h4, 32'h00A0_0113, 0);
        accept(1'b0, 64'h0, 1'b0);
        chk("t1_count", 64'(inst_count), 64'd2);

        // T2: five not-ready cycles, then branch forward to 0x40
        fetch(64'h8, 32'h0000_0013, 5);
        accept(1'b1, 64'h38, 1'b0);
        chk("t2_pc_sel", 64'(pc_sel), 64'd1);
        chk("t2_count", 64'(inst_count), 64'd3);

        // T3: backward branch -16 from 0x40, then halt
        fetch(64'h40, 32'h1111_1111, 0);
        accept(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        chk("t3_pc_sel", 64'(pc_sel), 64'd1);
        chk("t3_addr", bus.imem_addr, 64'h30);
        fetch(64'h30, 32'h2222_2222, 0);
        accept(1'b0, 64'h0, 1'b1);
        chk("halt_req", 64'(bus.imem_req), 64'd0);
        @(negedge clk);
        chk("halt_req_stays", 64'(bus.imem_req), 64'd0);
        chk("halt_addr", bus.imem_addr, 64'h34);
        chk("halt_count", 64'(inst_count), 64'd5);
        chk("halt_pc_sel", 64'(pc_sel), 64'd0);

        // T4: sequential step from the top of the address space wraps to 0
        kick();
        fetch(64'h34, 32'h3333_3333, 0);
        accept(1'b1, 64'hFFFF_FFFF_FFFF_FFC8, 1'b0);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h4444_4444, 0);
        accept(1'b0, 64'h0, 1'b0);
        chk("t4_err", 64'(err), 64'd0);
        chk("t4_pc_sel", 64'(pc_sel), 64'd0);
        fetch(64'h0, 32'h5555_5555, 0);
        accept(1'b1, 64'h8, 1'b0);

        // T5: misaligned target beats halt and parks in ERR
        fetch(64'h8, 32'h6666_6666, 0);
        accept(1'b1, 64'h6, 1'b1);
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_addr", bus.imem_addr, 64'hE);
        chk("t5_req", 64'(bus.imem_req), 64'd0);
        chk("t5_valid", 64'(bus.inst_valid), 64'd0);
        chk("t5_count", 64'(inst_count), 64'd9);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_req_stuck", 64'(bus.imem_req), 64'd0);
            chk("err_sticky", 64'(err), 64'd1);
        end
        start = 1'b0;

        // T6: reset mid-REQ with data arriving in the same cycle
        do_reset();
        chk("clr_err", 64'(err), 64'd0);
        kick();
        chk("t6_req", 64'(bus.imem_req), 64'd1);
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        chk("t6_valid", 64'(bus.inst_valid), 64'd0);
        chk("t6_inst", 64'(bus.inst), 64'd0);
        chk("t6_addr", bus.imem_addr, 64'h0);
        chk("t6_count", 64'(inst_count), 64'd0);
        chk("t6_req", 64'(bus.imem_req), 64'd0);
        kick();
        fetch(64'h0, 32'h7777_7777, 0);
        accept(1'b0, 64'h0, 1'b1);
        chk("t6_halt_req", 64'(bus.imem_req), 64'd0);
        chk("t6_halt_count", 64'(inst_count), 64'd1);
        chk("t6_halt_addr", bus.imem_addr, 64'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
